// File: rtl/temp_calc_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : temp_calc_scheduler
// Description : Round-robin scheduler sharing one combinational temperature
//               calculator across NCH sensor channels, with sticky alarms.
// Revision    : 1.0 - initial release
// ============================================================================
module temp_calc_scheduler #(
  parameter int NCH        = 4,
  parameter int SAMPLE_DIV = 64,
  localparam int CW        = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [4*NCH-1:0] sensorValue,
  input  logic             cfgWe,
  input  logic [CW-1:0]    cfgAddr,
  input  logic [7:0]       cfgBase,
  input  logic [3:0]       cfgCoef,
  input  logic [7:0]       highLimit,
  input  logic [7:0]       lowLimit,
  input  logic             alarmClr,
  output logic [7:0]       calcBase,
  output logic [3:0]       calcCoef,
  output logic [3:0]       calcSensor,
  input  logic [7:0]       calcTemp,
  output logic [7:0]       tempOut,
  output logic [CW-1:0]    tempCh,
  output logic             tempValid,
  output logic             scanDone,
  output logic             busy,
  output logic [NCH-1:0]   alarm
);

  localparam int TW = $clog2(SAMPLE_DIV);
  localparam logic [TW-1:0] c_timerMax = TW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] c_lastCh   = CW'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_ch;
  logic [TW-1:0]   r_timer;
  logic            w_tick;
  logic [7:0]      r_calBase [NCH];
  logic [3:0]      r_calCoef [NCH];
  logic [3:0]      w_sensor  [NCH];
  logic [NCH-1:0]  w_cfgSel;
  logic [NCH-1:0]  w_alarmSet;
  logic            w_outOfRange;
  logic [7:0]      r_calcBase;
  logic [3:0]      r_calcCoef;
  logic [3:0]      r_calcSensor;
  logic [7:0]      r_tempOut;
  logic [CW-1:0]   r_tempCh;
  logic            r_tempValid;
  logic            r_scanDone;
  logic            r_busy;
  logic [NCH-1:0]  r_alarm;

  assign w_outOfRange = (calcTemp > highLimit) || (calcTemp < lowLimit);

  // Per-channel slices: sensor unpacking, write decode and alarm set terms
  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    assign w_sensor[gi]   = sensorValue[4*gi +: 4];
    assign w_cfgSel[gi]   = cfgWe && (cfgAddr == CW'(gi));
    assign w_alarmSet[gi] = (r_state == CAPTURE) && (r_ch == CW'(gi)) && w_outOfRange;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        r_calBase[i] <= '0;
        r_calCoef[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_cfgSel[i]) begin
          r_calBase[i] <= cfgBase;
          r_calCoef[i] <= cfgCoef;
        end
      end
    end
  end

  // Free-running scan timer; disabling parks it at zero without touching a scan
  assign w_tick = enable && (r_timer == c_timerMax);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (!enable || w_tick) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_ch         <= '0;
      r_busy       <= 1'b0;
      r_calcBase   <= '0;
      r_calcCoef   <= '0;
      r_calcSensor <= '0;
      r_tempOut    <= '0;
      r_tempCh     <= '0;
      r_tempValid  <= 1'b0;
      r_scanDone   <= 1'b0;
    end else begin
      r_tempValid <= 1'b0;
      r_scanDone  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_tick) begin
            r_ch    <= '0;
            r_busy  <= 1'b1;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          r_calcBase   <= r_calBase[r_ch];
          r_calcCoef   <= r_calCoef[r_ch];
          r_calcSensor <= w_sensor[r_ch];
          r_state      <= CAPTURE;
        end
        CAPTURE: begin
          r_tempOut   <= calcTemp;
          r_tempCh    <= r_ch;
          r_tempValid <= 1'b1;
          if (r_ch == c_lastCh) begin
            r_scanDone <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end else begin
            r_ch    <= r_ch + 1'b1;
            r_state <= SETUP;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // A capture's set term overrides a simultaneous clear on its own channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alarm <= '0;
    end else begin
      r_alarm <= (alarmClr ? '0 : r_alarm) | w_alarmSet;
    end
  end

  assign calcBase   = r_calcBase;
  assign calcCoef   = r_calcCoef;
  assign calcSensor = r_calcSensor;
  assign tempOut    = r_tempOut;
  assign tempCh     = r_tempCh;
  assign tempValid  = r_tempValid;
  assign scanDone   = r_scanDone;
  assign busy       = r_busy;
  assign alarm      = r_alarm;

endmodule
`default_nettype wire

// File: tb/tb_temp_calc_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_temp_calc_scheduler
// Description : Directed/random bench for temp_calc_scheduler with a
//               schedule-based reference model of scans, alarms and calibration.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_temp_calc_scheduler;

  localparam int NCH = 4;
  localparam int SD  = 64;
  localparam int CW  = $clog2(NCH);

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic [4*NCH-1:0] sensorValue;
  logic             cfgWe;
  logic [CW-1:0]    cfgAddr;
  logic [7:0]       cfgBase;
  logic [3:0]       cfgCoef;
  logic [7:0]       highLimit;
  logic [7:0]       lowLimit;
  logic             alarmClr;
  logic [7:0]       calcBase;
  logic [3:0]       calcCoef;
  logic [3:0]       calcSensor;
  logic [7:0]       calcTemp;
  logic [7:0]       tempOut;
  logic [CW-1:0]    tempCh;
  logic             tempValid;
  logic             scanDone;
  logic             busy;
  logic [NCH-1:0]   alarm;

  temp_calc_scheduler #(.NCH(NCH), .SAMPLE_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sensorValue(sensorValue),
    .cfgWe(cfgWe), .cfgAddr(cfgAddr), .cfgBase(cfgBase), .cfgCoef(cfgCoef),
    .highLimit(highLimit), .lowLimit(lowLimit), .alarmClr(alarmClr),
    .calcBase(calcBase), .calcCoef(calcCoef), .calcSensor(calcSensor),
    .calcTemp(calcTemp), .tempOut(tempOut), .tempCh(tempCh),
    .tempValid(tempValid), .scanDone(scanDone), .busy(busy), .alarm(alarm)
  );

  // Calculator stand-in: base + coef*sensor, wrapped to 8 bits
  assign calcTemp = calcBase + ({4'd0, calcCoef} * {4'd0, calcSensor});

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int             nCmp;
  int             nFail;
  int             cyc;
  int             scanT;
  int             enStart;
  int             mBase, mCoef, mSens, mOut, mCh;
  bit             mValid, mDone, mBusy;
  logic [NCH-1:0] mAlarm;
  int             calB [NCH];
  int             calC [NCH];
  logic [7:0]     newB;
  logic [3:0]     newC;
  int             oldVal;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic modelReset();
    scanT = -1;
    mBase = 0; mCoef = 0; mSens = 0; mOut = 0; mCh = 0;
    mValid = 0; mDone = 0; mBusy = 0; mAlarm = '0;
    for (int i = 0; i < NCH; i++) begin
      calB[i] = 0;
      calC[i] = 0;
    end
  endtask

  // Advance the model over the current cycle, clock the DUT, compare everything
  task automatic step();
    int             c;
    int             p;
    int             k;
    logic [NCH-1:0] setMask;
    c       = cyc;
    setMask = '0;
    if (!rst_n) begin
      modelReset();
      enStart = c + 1;
    end else begin
      if (!enable) enStart = c + 1;
      mValid = 0;
      mDone  = 0;
      if (scanT >= 0) begin
        p = c - scanT;
        if (p % 2 == 1) begin
          k     = (p - 1) / 2;
          mBase = calB[k];
          mCoef = calC[k];
          mSens = int'(sensorValue[4*k +: 4]);
        end else begin
          k      = (p - 2) / 2;
          mOut   = (mBase + mCoef * mSens) % 256;
          mCh    = k;
          mValid = 1;
          mDone  = (k == NCH - 1);
          if (mOut > int'(highLimit) || mOut < int'(lowLimit)) setMask[k] = 1'b1;
        end
        if (p == 2 * NCH) scanT = -1;
      end else if (enable && ((c - enStart) % SD == SD - 1)) begin
        scanT = c;
      end
      mBusy = (scanT >= 0);
      if (alarmClr) mAlarm = '0;
      mAlarm = mAlarm | setMask;
      if (cfgWe && int'(cfgAddr) < NCH) begin
        calB[cfgAddr] = int'(cfgBase);
        calC[cfgAddr] = int'(cfgCoef);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    check("tempValid",  32'(tempValid),  32'(mValid));
    check("scanDone",   32'(scanDone),   32'(mDone));
    check("busy",       32'(busy),       32'(mBusy));
    check("tempOut",    32'(tempOut),    32'(mOut));
    check("tempCh",     32'(tempCh),     32'(mCh));
    check("alarm",      32'(alarm),      32'(mAlarm));
    check("calcBase",   32'(calcBase),   32'(mBase));
    check("calcCoef",   32'(calcCoef),   32'(mCoef));
    check("calcSensor", 32'(calcSensor), 32'(mSens));
  endtask

  task automatic runTo(input int target);
    while (cyc < target) step();
  endtask

  task automatic cfg(input int a, input logic [7:0] b, input logic [3:0] cf);
    cfgWe   = 1'b1;
    cfgAddr = CW'(a);
    cfgBase = b;
    cfgCoef = cf;
    step();
    cfgWe   = 1'b0;
  endtask

  initial begin
    nCmp = 0; nFail = 0; cyc = -3; enStart = 0;
    rst_n = 1'b0; enable = 1'b0; sensorValue = '0; cfgWe = 1'b0; cfgAddr = '0;
    cfgBase = '0; cfgCoef = '0; highLimit = 8'hFF; lowLimit = 8'h00; alarmClr = 1'b0;
    modelReset();
    repeat (3) step();

    // Reset release with enable; program calibration before the first tick
    rst_n = 1'b1; enable = 1'b1; highLimit = 8'h20; lowLimit = 8'h05;
    cfg(0, 8'h11, 4'd8);
    cfg(1, 8'h00, 4'd1);
    cfg(2, 8'h10, 4'd1);
    cfg(3, 8'h06, 4'd1);
    sensorValue = {4'($urandom), 4'($urandom), 4'd2, 4'd2};

    runTo(65);
    check("noValidBefore66", 32'(tempValid), 32'd0);
    runTo(66);
    check("firstValid", 32'(tempValid), 32'd1);
    check("ch0Temp", 32'(tempOut), 32'h21);
    check("ch0Tag", 32'(tempCh), 32'd0);
    runTo(68);
    check("ch1Temp", 32'(tempOut), 32'h02);
    check("ch1Tag", 32'(tempCh), 32'd1);
    runTo(72);
    check("lastDone", 32'(scanDone), 32'd1);
    check("lastTag", 32'(tempCh), 32'd3);
    runTo(73);
    check("alarmAfterScan", 32'(alarm), 32'b0011);

    // Second scan: clear coincides with ch0 capture (cycle 129)
    runTo(129);
    alarmClr = 1'b1;
    step();
    alarmClr = 1'b0;
    check("alarmSetWins", 32'(alarm), 32'b0001);

    runTo(150);
    sensorValue = 16'($urandom);

    // Third scan (tick 191): write ch2 during its SETUP cycle 196
    runTo(196);
    oldVal = (calB[2] + calC[2] * int'(sensorValue[11:8])) % 256;
    newB = 8'($urandom);
    newC = 4'($urandom);
    cfg(2, newB, newC);
    runTo(198);
    check("collisionTag", 32'(tempCh), 32'd2);
    check("collisionOld", 32'(tempOut), 32'(oldVal));
    runTo(262);
    check("collisionNew", 32'(tempOut), 32'((int'(newB) + int'(newC) * int'(sensorValue[11:8])) % 256));

    // Fifth scan (tick 319): reset during ch1 CAPTURE at cycle 323
    runTo(323);
    rst_n = 1'b0;
    #1;
    check("asyncValid", 32'(tempValid), 32'd0);
    check("asyncBusy", 32'(busy), 32'd0);
    check("asyncTempOut", 32'(tempOut), 32'd0);
    check("asyncTempCh", 32'(tempCh), 32'd0);
    check("asyncAlarm", 32'(alarm), 32'd0);
    check("asyncCalc", 32'({calcBase, calcCoef, calcSensor}), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    cfg(0, 8'($urandom), 4'($urandom));
    cfg(1, 8'($urandom), 4'($urandom));
    cfg(2, 8'($urandom), 4'($urandom));
    cfg(3, 8'($urandom), 4'($urandom));
    sensorValue = 16'($urandom);
    highLimit = 8'($urandom_range(255, 128));
    lowLimit  = 8'($urandom_range(127, 0));

    // Tick at 388; drop enable mid-scan at 390
    runTo(390);
    enable = 1'b0;
    runTo(397);
    check("disabledScanDone", 32'(scanDone), 32'd1);
    runTo(470);
    check("noTickWhenDisabled", 32'(busy), 32'd0);
    check("noStrobeWhenDisabled", 32'(tempValid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
`default_nettype wire
